// File: rtl/alu_arbiter_if.sv
// ============================================================================
// alu_arbiter_if : request/response bundle between two requesters and the ALU arbiter
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
   parameter int WIDTH = 32
) ();
   logic             req0_valid_i;
   logic             req0_ready_o;
   logic [2:0]       req0_ctrl_i;
   logic [WIDTH-1:0] req0_data1_i;
   logic [WIDTH-1:0] req0_data2_i;
   logic             req1_valid_i;
   logic             req1_ready_o;
   logic [2:0]       req1_ctrl_i;
   logic [WIDTH-1:0] req1_data1_i;
   logic [WIDTH-1:0] req1_data2_i;
   logic             resp0_valid_o;
   logic             resp0_ready_i;
   logic             resp1_valid_o;
   logic             resp1_ready_i;
   logic [WIDTH-1:0] resp_data_o;
   logic             resp_zero_o;
   logic             busy_o;

   modport slave (
      input  req0_valid_i, req0_ctrl_i, req0_data1_i, req0_data2_i,
      input  req1_valid_i, req1_ctrl_i, req1_data1_i, req1_data2_i,
      input  resp0_ready_i, resp1_ready_i,
      output req0_ready_o, req1_ready_o,
      output resp0_valid_o, resp1_valid_o, resp_data_o, resp_zero_o, busy_o
   );

   modport master (
      output req0_valid_i, req0_ctrl_i, req0_data1_i, req0_data2_i,
      output req1_valid_i, req1_ctrl_i, req1_data1_i, req1_data2_i,
      output resp0_ready_i, resp1_ready_i,
      input  req0_ready_o, req1_ready_o,
      input  resp0_valid_o, resp1_valid_o, resp_data_o, resp_zero_o, busy_o
   );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : round-robin sharing of one integer ALU between two requesters
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 3
) (
   input  wire logic     clk_i,
   input  wire logic     rst_i,
   alu_arbiter_if.slave  bus
);
   localparam int               SHW       = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] C_WIDTH_V = WIDTH'(WIDTH);
   localparam logic [3:0]       C_MUL_CNT = 4'(MUL_LAT - 1);
   localparam logic [2:0]       C_ADD = 3'b000, C_SLL = 3'b001, C_MUL = 3'b010, C_ZRO = 3'b011;
   localparam logic [2:0]       C_XOR = 3'b100, C_SRA = 3'b101, C_SUB = 3'b110, C_AND = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_last_grant;
   logic             r_owner;
   logic [3:0]       r_cnt;
   logic [2:0]       r_ctrl;
   logic [WIDTH-1:0] r_d1;
   logic [WIDTH-1:0] r_d2;
   logic [WIDTH-1:0] r_resp_data;
   logic             r_resp_zero;

   logic             w_idle;
   logic             w_rdy0;
   logic             w_rdy1;
   logic             w_owner_ack;
   logic [WIDTH-1:0] w_alu;

   // On contention the requester not granted last wins; reset gates the readies low.
   assign w_idle = (r_state == S_IDLE) && !rst_i;
   assign w_rdy0 = w_idle && bus.req0_valid_i && (!bus.req1_valid_i || r_last_grant);
   assign w_rdy1 = w_idle && bus.req1_valid_i && (!bus.req0_valid_i || !r_last_grant);
   assign w_owner_ack = r_owner ? bus.resp1_ready_i : bus.resp0_ready_i;

   always_comb begin
      w_alu = '0;
      case (r_ctrl)
         C_ADD: w_alu = r_d1 + r_d2;
         C_SUB: w_alu = r_d1 - r_d2;
         C_MUL: w_alu = r_d1 * r_d2;
         C_AND: w_alu = r_d1 & r_d2;
         C_XOR: w_alu = r_d1 ^ r_d2;
         C_SLL: w_alu = (r_d2 >= C_WIDTH_V) ? '0 : (r_d1 << r_d2[SHW-1:0]);
         C_SRA: w_alu = $signed(r_d1) >>> r_d2[SHW-1:0];
         C_ZRO: w_alu = '0;
         default: w_alu = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_cnt        <= '0;
         r_ctrl       <= '0;
         r_d1         <= '0;
         r_d2         <= '0;
         r_resp_data  <= '0;
         r_resp_zero  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_rdy0 || w_rdy1) begin
                  r_owner      <= w_rdy1;
                  r_last_grant <= w_rdy1;
                  r_ctrl       <= w_rdy1 ? bus.req1_ctrl_i  : bus.req0_ctrl_i;
                  r_d1         <= w_rdy1 ? bus.req1_data1_i : bus.req0_data1_i;
                  r_d2         <= w_rdy1 ? bus.req1_data2_i : bus.req0_data2_i;
                  r_cnt        <= ((w_rdy1 ? bus.req1_ctrl_i : bus.req0_ctrl_i) == C_MUL)
                                  ? C_MUL_CNT : 4'd0;
                  r_state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_resp_data <= w_alu;
                  r_resp_zero <= (w_alu == '0);
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (w_owner_ack) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req0_ready_o  = w_rdy0;
   assign bus.req1_ready_o  = w_rdy1;
   assign bus.resp0_valid_o = (r_state == S_RESP) && !r_owner;
   assign bus.resp1_valid_o = (r_state == S_RESP) &&  r_owner;
   assign bus.resp_data_o   = r_resp_data;
   assign bus.resp_zero_o   = r_resp_zero;
   assign bus.busy_o        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter : directed stimulus with a response scoreboard for alu_arbiter
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
   localparam logic [2:0] ADD = 3'b000, SLL = 3'b001, MUL = 3'b010, ZRO = 3'b011;
   localparam logic [2:0] XOR = 3'b100, SRA = 3'b101, SUB = 3'b110, AND = 3'b111;

   typedef struct {
      bit          owner;
      logic [31:0] data;
      int          acc;
      int          lat;
      bit          seen;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;
   int   hs_cyc[2];
   exp_t exp_q[$];

   alu_arbiter_if #(.WIDTH(32)) bus ();

   alu_arbiter #(.WIDTH(32), .MUL_LAT(3)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog cycle=%0d required=finish", cyc);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: compares every presented response against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.resp0_valid_o && bus.resp1_valid_o) begin
            chk("resp_valid_both", 32'd1, 32'd0);
         end else if (bus.resp0_valid_o || bus.resp1_valid_o) begin
            if (exp_q.size() == 0) begin
               chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
               chk("resp_owner", 32'(bus.resp1_valid_o), 32'(exp_q[0].owner));
               chk("resp_data", bus.resp_data_o, exp_q[0].data);
               chk("resp_zero", 32'(bus.resp_zero_o), 32'(exp_q[0].data == 32'd0));
               if (!exp_q[0].seen) begin
                  chk("resp_latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
                  exp_q[0].seen = 1'b1;
               end
               if ((bus.resp0_valid_o && bus.resp0_ready_i) ||
                   (bus.resp1_valid_o && bus.resp1_ready_i)) begin
                  hs_cyc[bus.resp1_valid_o ? 1 : 0] = cyc;
                  void'(exp_q.pop_front());
               end
            end
         end
         if (bus.busy_o && (bus.req0_valid_i || bus.req1_valid_i)) begin
            chk("ready_while_busy", 32'(bus.req0_ready_o || bus.req1_ready_o), 32'd0);
         end
      end
   end

   task automatic issue(input int id, input logic [2:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit push, output int acc);
      bit got;
      exp_t e;
      got = 1'b0;
      acc = -1;
      @(posedge clk) #1;
      if (id == 0) begin
         bus.req0_valid_i = 1'b1; bus.req0_ctrl_i = ctrl;
         bus.req0_data1_i = a;    bus.req0_data2_i = b;
      end else begin
         bus.req1_valid_i = 1'b1; bus.req1_ctrl_i = ctrl;
         bus.req1_data1_i = a;    bus.req1_data2_i = b;
      end
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         if ((id == 0) ? bus.req0_ready_o : bus.req1_ready_o) begin
            got = 1'b1;
            acc = cyc;
            if (push) begin
               e.owner = (id != 0); e.data = exp; e.acc = cyc; e.lat = lat; e.seen = 1'b0;
               exp_q.push_back(e);
            end
         end
      end
      if (!got) chk("req_accept_timeout", 32'd0, 32'd1);
      @(posedge clk) #1;
      if (id == 0) bus.req0_valid_i = 1'b0;
      else         bus.req1_valid_i = 1'b0;
   endtask

   initial begin
      int a0[2];
      int a1[2];
      int acc0;
      int acc1;
      int dummy;
      bit seen;
      checks = 0;
      errors = 0;
      hs_cyc[0] = -1;
      hs_cyc[1] = -1;
      rst = 1'b1;
      bus.req0_valid_i = 1'b0; bus.req0_ctrl_i = '0; bus.req0_data1_i = '0; bus.req0_data2_i = '0;
      bus.req1_valid_i = 1'b0; bus.req1_ctrl_i = '0; bus.req1_data1_i = '0; bus.req1_data2_i = '0;
      bus.resp0_ready_i = 1'b1;
      bus.resp1_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", 32'(bus.busy_o), 32'd0);
      chk("reset_data", bus.resp_data_o, 32'd0);
      chk("reset_zero", 32'(bus.resp_zero_o), 32'd0);
      chk("reset_valids", 32'({bus.resp0_valid_o, bus.resp1_valid_o}), 32'd0);
      @(posedge clk) #1;
      rst = 1'b0;

      issue(0, ADD, 32'd5, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 2, 1'b1, dummy);
      issue(1, MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 4, 1'b1, dummy);

      // Contention with resp ready tied high: strict alternation, one grant per 3 cycles.
      fork
         begin
            for (int i = 0; i < 2; i++)
               issue(0, SUB, 32'd9, 32'd9, 32'd0, 2, 1'b1, a0[i]);
         end
         begin
            for (int i = 0; i < 2; i++)
               issue(1, SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 2, 1'b1, a1[i]);
         end
      join
      chk("rr_gap_0_1", 32'(a1[0] - a0[0]), 32'd3);
      chk("rr_gap_1_0", 32'(a0[1] - a1[0]), 32'd3);
      chk("rr_gap_0_1b", 32'(a1[1] - a0[1]), 32'd3);

      // Backpressure on resp0 while requester 1 waits.
      bus.resp0_ready_i = 1'b0;
      issue(0, XOR, 32'hFF, 32'h0F, 32'hF0, 2, 1'b1, dummy);
      fork
         issue(1, ADD, 32'd1, 32'd2, 32'd3, 2, 1'b1, acc1);
         begin
            seen = 1'b0;
            for (int n = 0; n < 50 && !seen; n++) begin
               @(negedge clk);
               seen = bus.resp0_valid_o;
            end
            if (!seen) chk("stall_resp_timeout", 32'd0, 32'd1);
            repeat (5) @(negedge clk);
            chk("stall_req1_ready", 32'(bus.req1_ready_o), 32'd0);
            @(posedge clk) #1;
            bus.resp0_ready_i = 1'b1;
         end
      join
      chk("stall_grant_after_hs", 32'(acc1), 32'(hs_cyc[0] + 1));

      issue(0, SLL, 32'd1, 32'd31, 32'h8000_0000, 2, 1'b1, dummy);
      issue(0, SLL, 32'd1, 32'd32, 32'd0, 2, 1'b1, dummy);
      issue(0, SRA, 32'hFFFF_FFFF, 32'h25, 32'hFFFF_FFFF, 2, 1'b1, dummy);
      issue(0, ZRO, 32'd7, 32'd9, 32'd0, 2, 1'b1, dummy);
      issue(1, AND, 32'hF0F0, 32'hFF00, 32'hF000, 2, 1'b1, dummy);
      issue(0, MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 4, 1'b1, dummy);

      // Reset mid-EXEC of a MUL: dropped op, arbitration pointer restored.
      issue(0, MUL, 32'd3, 32'd4, 32'd12, 4, 1'b0, dummy);
      rst = 1'b1;
      @(posedge clk) #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(bus.busy_o), 32'd0);
      chk("midrst_data", bus.resp_data_o, 32'd0);
      chk("midrst_valids", 32'({bus.resp0_valid_o, bus.resp1_valid_o}), 32'd0);
      repeat (6) @(negedge clk);
      fork
         issue(0, ADD, 32'd1, 32'd1, 32'd2, 2, 1'b1, acc0);
         issue(1, ADD, 32'd2, 32'd2, 32'd4, 2, 1'b1, acc1);
      join
      chk("midrst_grant_req0", 32'(acc0 < acc1), 32'd1);

      for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 32-bit integer ALU between two requesters (e.g. execute stage and a multi-cycle helper unit) using valid/ready handshakes.
- Round-robin arbitration. Operands are latched at grant. MUL runs for a parameterised number of cycles; all other ops take a single execute cycle.
- The result is returned on a registered response channel, steered to the granted requester, and held until that requester accepts it.
- Contains its own combinational ALU core using the team's 3-bit ALU control encoding.

Parameters:
- WIDTH, 32, operand/result width.
- MUL_LAT, 3, execute cycles for MUL (legal range 1..15); all other ops use 1.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req0_valid_i  input  1  requester 0 has an op.
- req0_ready_o  output  1  requester 0 op accepted this cycle.
- req0_ctrl_i  input  3  ALU control code.
- req0_data1_i  input  WIDTH  operand 1 (signed).
- req0_data2_i  input  WIDTH  operand 2 (signed).
- req1_valid_i / req1_ready_o / req1_ctrl_i / req1_data1_i / req1_data2_i: same as the requester 0 ports, for requester 1.
- resp0_valid_o  output  1  result available for requester 0.
- resp0_ready_i  input  1  requester 0 takes the result.
- resp1_valid_o  output  1  result available for requester 1.
- resp1_ready_i  input  1  requester 1 takes the result.
- resp_data_o  output  WIDTH  result (shared by both response channels).
- resp_zero_o  output  1  1 when resp_data_o == 0.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Ctrl encoding:
  - 000 ADD, 110 SUB, 010 MUL (low WIDTH bits of the product), 111 AND, 100 XOR.
  - 001 SLL: shift by the full data2 value; result is 0 when data2 >= WIDTH.
  - 101 SRA: arithmetic shift by data2[4:0].
  - 011: result 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - The grant goes to the sole valid requester.
  - If both requesters are valid, the grant goes to the one not granted last (last_grant register).
  - reqN_ready_o is combinational and high only for the granted requester, in IDLE only. The other ready stays low.
  - On handshake, latch ctrl, data1, data2 and the owner id; set last_grant = owner.
  - Load cnt = MUL_LAT-1 for MUL, 0 otherwise; go to EXEC.
- EXEC:
  - If cnt != 0, decrement and stay in EXEC.
  - If cnt == 0, register the ALU result into resp_data_o and resp_zero_o, and go to RESP.
- RESP:
  - respN_valid_o is high for the owner only.
  - resp_data_o and resp_zero_o stay stable while in RESP.
  - On respN_ready_i of the owner, go to IDLE next cycle.
  - The non-owner's resp ready input is ignored.
- Latency: an op accepted in cycle T asserts resp valid in cycle T+2 (non-MUL) or T+1+MUL_LAT (MUL).
  - If resp ready is already high, the next accept happens no earlier than the cycle after the response handshake.
  - Peak throughput is one op per 3 cycles.
- No accept while busy: both req ready outputs stay 0 in EXEC and RESP, whatever the req valids.
- Requesters hold their inputs stable while valid and not ready. The block samples operands only at the handshake cycle.
- Reset (any state, including mid-EXEC or RESP):
  - state = IDLE, last_grant = 1 (so requester 0 wins the first contention), cnt = 0.
  - resp_data_o = 0, resp_zero_o = 0, all valid/ready outputs = 0, busy_o = 0.
  - An in-flight op is dropped and no response is issued.
- Simultaneous events:
  - A valid request arriving during RESP waits in the requester.
  - A response handshake and a new request in the same cycle: the request is granted in the following IDLE cycle.

Test Plan:
- Reset, then req0 ADD 5 + (-7) -> req0_ready_o=1 at T; resp0_valid_o at T+2 with resp_data_o=-2 (0xFFFFFFFE), resp_zero_o=0; resp1_valid_o stays 0.
- req1 MUL 0x10000 * 0x10000 with MUL_LAT=3 -> resp1_valid_o at T+4, resp_data_o=0; resp_zero_o=1.
- Both valid every cycle with resp ready tied high, ops SUB 9-9 (req0) and SRA 0x80000000>>>4 (req1):
  - grants alternate 0,1,0,1;
  - results alternate 0 (zero=1) and 0xF8000000;
  - a grant occurs every 3 cycles.
- Backpressure: hold resp0_ready_i=0 for 5 cycles after XOR 0xFF^0x0F -> resp0_valid_o and resp_data_o=0xF0 held stable; req1 valid during the stall sees ready=0; req1 is granted the cycle after the resp0 handshake.
- Boundary ops:
  - SLL 1<<31 -> 0x80000000.
  - SLL 1<<32 -> 0.
  - SRA -1>>>0x25 (data2[4:0]=5) -> -1.
  - ctrl 011 -> 0 with zero=1.
- Assert rst_i for one cycle mid-EXEC of a MUL -> no resp valid afterwards, busy_o=0; next contention grants requester 0.
